// File: rtl/bit_4_cla_pkg.sv
// Shared types and width constant for the 4-bit carry-lookahead adder.
package bit_4_cla_pkg;

  localparam int unsigned CLA_W = 4;

  typedef logic [CLA_W-1:0] nibble_t;

  typedef struct packed {
    nibble_t g;
    nibble_t p;
  } pg_t;

endpackage

// File: rtl/cla_carry_unit.sv
// Flat sum-of-products lookahead carries for one 4-bit group.
// Group propagate/generate outputs exist only when BIT_4_CLA_GROUP_PG_EN is defined.
module cla_carry_unit
  import bit_4_cla_pkg::*;
(
  input  pg_t            pg,
  input  logic           cin,
`ifdef BIT_4_CLA_GROUP_PG_EN
  output logic           grp_p,
  output logic           grp_g,
`endif
  output logic [CLA_W:0] c
);

  nibble_t g;
  nibble_t p;

  assign g = pg.g;
  assign p = pg.p;

  // Every carry is expanded directly from g/p/cin so no term depends on a lower carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & cin);

`ifdef BIT_4_CLA_GROUP_PG_EN
  assign grp_p = &p;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
`endif

endmodule

// File: rtl/bit_4_cla.sv
// 4-bit carry-lookahead adder with one registered output stage.
// Define BIT_4_CLA_GROUP_PG_EN to add registered group propagate/generate outputs.
module bit_4_cla
  import bit_4_cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             cin,
`ifdef BIT_4_CLA_GROUP_PG_EN
  output logic             grp_p,
  output logic             grp_g,
`endif
  output logic [CLA_W-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  pg_t              pg;
  logic [CLA_W:0]   c;
  nibble_t          sum_d;
  nibble_t          sum_q;
  logic             cout_q;
  logic             out_valid_q;

  assign pg.g = a & b;
  assign pg.p = a ^ b;

`ifdef BIT_4_CLA_GROUP_PG_EN
  logic grp_p_d;
  logic grp_g_d;
  logic grp_p_q;
  logic grp_g_q;
`endif

  cla_carry_unit u_carry (
    .pg    (pg),
    .cin   (cin),
`ifdef BIT_4_CLA_GROUP_PG_EN
    .grp_p (grp_p_d),
    .grp_g (grp_g_d),
`endif
    .c     (c)
  );

  assign sum_d = pg.p ^ c[CLA_W-1:0];

  // Data registers only load on in_valid, so unknown operands on idle cycles never propagate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= c[CLA_W];
      end
    end
  end

`ifdef BIT_4_CLA_GROUP_PG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
    end else if (in_valid) begin
      grp_p_q <= grp_p_d;
      grp_g_q <= grp_g_d;
    end
  end

  assign grp_p = grp_p_q;
  assign grp_g = grp_g_q;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bit_4_cla.sv
// Directed and exhaustive self-checking bench for bit_4_cla.
// Covers the group P/G outputs as well when BIT_4_CLA_GROUP_PG_EN is defined.
module tb_bit_4_cla;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       out_valid;
`ifdef BIT_4_CLA_GROUP_PG_EN
  logic       grp_p;
  logic       grp_g;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  bit_4_cla dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BIT_4_CLA_GROUP_PG_EN
    .grp_p     (grp_p),
    .grp_g     (grp_g),
`endif
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ai, input logic [3:0] bi, input logic ci);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
  endtask

  task automatic add_chk(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                         input logic ci, input logic [3:0] exp_sum, input logic exp_cout);
    drive(1'b1, ai, bi, ci);
    step();
    check_val({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_val({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check_val({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [8:0] v;
    logic [4:0] exp5;

    rst = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 1'b1);

    // Reset dominates a valid max-value operand for two cycles.
    for (int k = 0; k < 2; k++) begin
      step();
      check_val("rst_sum", 32'(sum), 32'd0);
      check_val("rst_cout", 32'(cout), 32'd0);
      check_val("rst_vld", 32'(out_valid), 32'd0);
`ifdef BIT_4_CLA_GROUP_PG_EN
      check_val("rst_grp_p", 32'(grp_p), 32'd0);
      check_val("rst_grp_g", 32'(grp_g), 32'd0);
`endif
    end
    rst = 1'b0;

    // Exhaustive sweep, one operand set per cycle.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      drive(1'b1, v[8:5], v[4:1], v[0]);
      exp5 = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
      step();
      check_val("sweep_res", 32'({cout, sum}), 32'(exp5));
      check_val("sweep_vld", 32'(out_valid), 32'd1);
    end

    add_chk("prop_f0", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
    add_chk("prop_5a", 4'h5, 4'hA, 1'b0, 4'hF, 1'b0);
    add_chk("max", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    add_chk("plain", 4'h6, 4'h7, 1'b1, 4'hE, 1'b0);

    // Hold: idle cycles keep the last result even with changed or unknown operands.
    add_chk("hold_ld", 4'h3, 4'h4, 1'b0, 4'h7, 1'b0);
    drive(1'b0, 4'h9, 4'h9, 1'b0);
    step();
    check_val("hold_sum", 32'(sum), 32'h7);
    check_val("hold_cout", 32'(cout), 32'd0);
    check_val("hold_vld", 32'(out_valid), 32'd0);
    drive(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
    step();
    check_val("holdx_sum", 32'(sum), 32'h7);
    check_val("holdx_cout", 32'(cout), 32'd0);
    check_val("holdx_vld", 32'(out_valid), 32'd0);

    // Mid-stream reset discards the in-flight operand.
    add_chk("pre_rst", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    drive(1'b1, 4'h8, 4'h8, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mrst_sum", 32'(sum), 32'd0);
    check_val("mrst_cout", 32'(cout), 32'd0);
    check_val("mrst_vld", 32'(out_valid), 32'd0);

`ifdef BIT_4_CLA_GROUP_PG_EN
    add_chk("grp_f0", 4'hF, 4'h0, 1'b0, 4'hF, 1'b0);
    check_val("grp_f0_p", 32'(grp_p), 32'd1);
    check_val("grp_f0_g", 32'(grp_g), 32'd0);
    add_chk("grp_88", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);
    check_val("grp_88_p", 32'(grp_p), 32'd0);
    check_val("grp_88_g", 32'(grp_g), 32'd1);
    drive(1'b0, 4'hF, 4'h0, 1'b0);
    step();
    check_val("grp_hold_p", 32'(grp_p), 32'd0);
    check_val("grp_hold_g", 32'(grp_g), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_4_cla.md
Name: bit_4_cla

Overview:
- 4-bit carry-lookahead adder: sum = a + b + cin, with carry-out.
- Carries are computed in parallel from per-bit generate/propagate terms; there is no ripple chain.
- Combinational CLA core followed by one output register stage.
- Used as the arithmetic leaf block for wider adders and datapath units.

Parameters:
- None. Width is fixed at 4 by the package constant CLA_W = 4. This is not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands are valid this cycle
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry-in
- sum  output  4  registered a+b+cin, bits [3:0]
- cout  output  1  registered carry-out (bit 4 of a+b+cin)
- out_valid  output  1  sum/cout hold a new result

Behaviour:
- Per bit i in 0..3:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
- Lookahead carries, each expanded as a flat sum-of-products with no chaining:
  - c0 = cin
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
- sum_next[i] = p[i] ^ c[i]; cout_next = c4.
- Result width is 5 bits {cout, sum}. Range is 0..31, so no overflow is possible. Signed overflow is not flagged.
- Latency is exactly 1 cycle. On each rising clk edge with rst=0:
  - out_valid <= in_valid
  - if in_valid=1: sum <= sum_next, cout <= cout_next
  - if in_valid=0: sum and cout hold their previous values
- Reset (rst=1 at a rising edge): sum=4'h0, cout=0, out_valid=0. Reset overrides in_valid in the same cycle. Reset mid-stream discards the in-flight result.
- Back-to-back operation: a new operand is accepted every cycle. There is no backpressure and no ready signal.
- X/unknown inputs while in_valid=0 must not change the outputs.

Optional Feature:
- Macro: BIT_4_CLA_GROUP_PG_EN.
- When defined, add two outputs:
  - grp_p (1 bit) = p3·p2·p1·p0
  - grp_g (1 bit) = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
- Both are registered under the same in_valid/rst rules as sum; their reset value is 0. They allow cascading into a second-level lookahead unit.
- When not defined, these ports and their registers are absent. sum/cout/out_valid behaviour is identical in both builds.

Decomposition:
- Package bit_4_cla_pkg:
  - localparam CLA_W = 4
  - typedef logic [CLA_W-1:0] nibble_t
  - typedef struct {nibble_t g; nibble_t p;} pg_t
- Sub-module cla_carry_unit: purely combinational. Inputs are pg_t and cin; outputs are c[4:0] and, optionally, grp_p/grp_g.
- The top level holds the g/p generation, the sum XORs and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=4'hF, b=4'hF, cin=1, in_valid=1 -> sum=0, cout=0, out_valid=0 throughout.
- Exhaustive sweep: all 512 {a,b,cin} combinations, one per cycle, in_valid=1 -> one cycle later {cout,sum} == a+b+cin and out_valid=1.
- Full carry propagate: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1. Also a=4'h5, b=4'hA, cin=0 -> sum=4'hF, cout=0.
- Max inputs: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
- Hold: a=3, b=4, cin=0 with in_valid=1, then in_valid=0 with a=9, b=9 -> sum stays 4'h7, cout stays 0, out_valid drops to 0.
- Mid-stream reset: apply a=8, b=8 with in_valid=1 and rst=1 in the same cycle -> next cycle sum=0, cout=0, out_valid=0. With BIT_4_CLA_GROUP_PG_EN defined: a=4'hF, b=0, cin=0 -> grp_p=1, grp_g=0.
